// File: rtl/uart_pkg.sv
// Shared UART definitions: arbiter state encoding, byte width and default timeout.
package uart_pkg;

    localparam int unsigned UART_BYTE_W     = 8;
    localparam int unsigned DEFAULT_TIMEOUT = 200000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        ACK  = 2'd2
    } arb_state_e;

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin pick: first set req bit searching upward from last+1, wrapping.
module rr_picker #(
    parameter int unsigned N  = 4,
    parameter int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last,
    output logic [IW-1:0] winner,
    output logic          valid
);

    logic [IW-1:0] idx;

    // Walk the search order backwards so the nearest candidate to last+1 is assigned last.
    always_comb begin
        winner = '0;
        valid  = 1'b0;
        idx    = '0;
        for (int k = int'(N); k >= 1; k--) begin
            idx = IW'((int'(last) + k) % int'(N));
            if (req[idx]) begin
                winner = idx;
                valid  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arb.sv
// Round-robin arbiter sharing one UART TX core among N_REQ byte producers,
// with packet lock and a done watchdog.
module uart_tx_arb
    import uart_pkg::*;
#(
    parameter int unsigned N_REQ   = 4,
    parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [N_REQ-1:0]                   req,
    input  logic [N_REQ-1:0]                   req_lock,
    input  logic [UART_BYTE_W*N_REQ-1:0]       req_data,
    output logic [N_REQ-1:0]                   req_ack,
    output logic                               tx_start,
    output logic [UART_BYTE_W-1:0]             tx_data,
    input  logic                               tx_done,
    output logic [((N_REQ > 1) ? $clog2(N_REQ) : 1)-1:0] grant_id,
    output logic                               busy,
    output logic                               err
);

    localparam int unsigned IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    arb_state_e             state, state_nx;
    logic [IW-1:0]          last, last_d;
    logic                   lock_hold, lock_hold_d;
    logic [CW-1:0]          cnt, cnt_d;

    logic [N_REQ-1:0]       req_ack_d;
    logic                   tx_start_d, busy_d, err_d;
    logic [UART_BYTE_W-1:0] tx_data_d;
    logic [IW-1:0]          grant_id_d;

    logic [IW-1:0]          pick_id, sel_id;
    logic                   pick_valid, sel_valid, lock_win;
    logic                   done_ok, timeout_hit;

    rr_picker #(.N(N_REQ), .IW(IW)) u_picker (
        .req    (req),
        .last   (last),
        .winner (pick_id),
        .valid  (pick_valid)
    );

    // A held lock overrides round robin only while its owner is still requesting.
    always_comb begin
        lock_win    = lock_hold && req[grant_id];
        sel_id      = lock_win ? grant_id : pick_id;
        sel_valid   = lock_win || pick_valid;
        done_ok     = tx_done && !tx_start;
        timeout_hit = (cnt == CW'(TIMEOUT - 1));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            last      <= IW'(N_REQ - 1);
            lock_hold <= 1'b0;
            cnt       <= '0;
            req_ack   <= '0;
            tx_start  <= 1'b0;
            tx_data   <= '0;
            grant_id  <= '0;
            busy      <= 1'b0;
            err       <= 1'b0;
        end else begin
            state     <= state_nx;
            last      <= last_d;
            lock_hold <= lock_hold_d;
            cnt       <= cnt_d;
            req_ack   <= req_ack_d;
            tx_start  <= tx_start_d;
            tx_data   <= tx_data_d;
            grant_id  <= grant_id_d;
            busy      <= busy_d;
            err       <= err_d;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (sel_valid) state_nx = WAIT;
            WAIT:    if (done_ok || timeout_hit) state_nx = ACK;
            ACK:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Next values for every registered output and datapath register.
    always_comb begin
        req_ack_d   = '0;
        tx_start_d  = 1'b0;
        err_d       = 1'b0;
        busy_d      = (state_nx != IDLE);
        tx_data_d   = tx_data;
        grant_id_d  = grant_id;
        last_d      = last;
        lock_hold_d = lock_hold;
        cnt_d       = cnt;
        case (state)
            IDLE: begin
                if (lock_hold && !req[grant_id]) lock_hold_d = 1'b0;
                if (sel_valid) begin
                    grant_id_d = sel_id;
                    tx_data_d  = req_data[32'(sel_id) * UART_BYTE_W +: UART_BYTE_W];
                    tx_start_d = 1'b1;
                    cnt_d      = '0;
                end
            end
            WAIT: begin
                cnt_d = cnt + CW'(1);
                if (done_ok || timeout_hit) begin
                    req_ack_d[grant_id] = 1'b1;
                    err_d               = !done_ok;
                end
            end
            ACK: begin
                last_d      = grant_id;
                lock_hold_d = req_lock[grant_id];
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_uart_tx_arb.sv
// Directed self-checking bench for uart_tx_arb (N_REQ=4, TIMEOUT=50).
module tb_uart_tx_arb;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req;
    logic [3:0]  req_lock;
    logic [31:0] req_data;
    logic [3:0]  req_ack;
    logic        tx_start;
    logic [7:0]  tx_data;
    logic        tx_done;
    logic [1:0]  grant_id;
    logic        busy;
    logic        err;

    int tests = 0;
    int fails = 0;

    uart_tx_arb #(.N_REQ(4), .TIMEOUT(50)) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .req_lock (req_lock),
        .req_data (req_data),
        .req_ack  (req_ack),
        .tx_start (tx_start),
        .tx_data  (tx_data),
        .tx_done  (tx_done),
        .grant_id (grant_id),
        .busy     (busy),
        .err      (err)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        step();
    endtask

    // Emulates the TX core for one byte; returns in the ACK cycle.
    task automatic serve(input int delay, input logic [3:0] lock_val,
                         output logic [7:0] d, output logic [1:0] g,
                         output logic [3:0] ack, output logic e,
                         output int waited, output bit ok);
        ok = 1'b0; waited = 0; d = '0; g = '0; ack = '0; e = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (tx_start === 1'b1) begin
                ok = 1'b1;
                break;
            end
            step();
            waited++;
        end
        if (!ok) return;
        d = tx_data;
        g = grant_id;
        req_lock = lock_val;
        repeat (delay) step();
        tx_done = 1'b1;
        step();
        tx_done = 1'b0;
        ack = req_ack;
        e   = err;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        tests++; if (tx_start !== 1'b0) begin fails++; $display("FAIL reset_tx_start: got %b want 0", tx_start); end
        tests++; if (tx_data !== 8'h00) begin fails++; $display("FAIL reset_tx_data: got %h want 00", tx_data); end
        tests++; if (req_ack !== 4'b0000) begin fails++; $display("FAIL reset_req_ack: got %b want 0000", req_ack); end
        tests++; if (grant_id !== 2'd0) begin fails++; $display("FAIL reset_grant_id: got %0d want 0", grant_id); end
        tests++; if ({busy, err} !== 2'b00) begin fails++; $display("FAIL reset_busy_err: got %b want 00", {busy, err}); end
        rst = 1'b0;
        step();
    endtask

    task automatic test_single();
        req_data = 32'h00A5_0000;
        req = 4'b0100;
        step();
        tests++; if (tx_start !== 1'b1) begin fails++; $display("FAIL single_start: got %b want 1", tx_start); end
        tests++; if (tx_data !== 8'hA5) begin fails++; $display("FAIL single_data: got %h want a5", tx_data); end
        tests++; if (grant_id !== 2'd2) begin fails++; $display("FAIL single_grant: got %0d want 2", grant_id); end
        tests++; if (busy !== 1'b1) begin fails++; $display("FAIL single_busy: got %b want 1", busy); end
        step();
        tests++; if (tx_start !== 1'b0) begin fails++; $display("FAIL single_start_pulse: got %b want 0", tx_start); end
        repeat (9) step();
        tx_done = 1'b1;
        step();
        tx_done = 1'b0;
        tests++; if (req_ack !== 4'b0100) begin fails++; $display("FAIL single_ack: got %b want 0100", req_ack); end
        tests++; if (err !== 1'b0) begin fails++; $display("FAIL single_err: got %b want 0", err); end
        req = 4'b0000;
        step();
        tests++; if (req_ack !== 4'b0000) begin fails++; $display("FAIL single_ack_pulse: got %b want 0000", req_ack); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL single_idle_busy: got %b want 0", busy); end
    endtask

    task automatic test_first_cycle_done();
        logic [7:0] d; logic [1:0] g; logic [3:0] a; logic e; int w; bit ok;
        do_reset();
        req_data = 32'h0077_0000;
        req = 4'b0100;
        step();
        tx_done = 1'b1;
        step();
        tx_done = 1'b0;
        step();
        tests++; if (req_ack !== 4'b0000) begin fails++; $display("FAIL early_done_ack: got %b want 0000", req_ack); end
        tests++; if (busy !== 1'b1) begin fails++; $display("FAIL early_done_busy: got %b want 1", busy); end
        tx_done = 1'b1;
        step();
        tx_done = 1'b0;
        tests++; if (req_ack !== 4'b0100) begin fails++; $display("FAIL early_done_late_ack: got %b want 0100", req_ack); end
        req = 4'b0000;
        step();
        if (0) serve(0, 4'b0, d, g, a, e, w, ok);
    endtask

    task automatic test_contention();
        logic [7:0] d; logic [1:0] g; logic [3:0] a; logic e; int w; bit ok;
        logic [7:0] exp_d [5];
        logic [1:0] exp_g [5];
        exp_d = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h10};
        exp_g = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        req_data = 32'h1312_1110;
        req = 4'b1111;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            serve(3, 4'b0000, d, g, a, e, w, ok);
            tests++; if (!ok) begin fails++; $display("FAIL contention_timeout%0d: no tx_start within bound", i); end
            tests++; if (d !== exp_d[i]) begin fails++; $display("FAIL contention_data%0d: got %h want %h", i, d, exp_d[i]); end
            tests++; if (a !== (4'b0001 << exp_g[i])) begin fails++; $display("FAIL contention_ack%0d: got %b want %b", i, a, 4'b0001 << exp_g[i]); end
            if (i > 0) begin
                tests++; if (w !== 2) begin fails++; $display("FAIL contention_gap%0d: got %0d want 2", i, w); end
            end
        end
        req = 4'b0000;
        step();
    endtask

    task automatic test_lock();
        logic [7:0] d; logic [1:0] g; logic [3:0] a; logic e; int w; bit ok;
        logic [3:0] lk [4];
        logic [1:0] exp_g [4];
        lk    = '{4'b0010, 4'b0010, 4'b0000, 4'b0000};
        exp_g = '{2'd1, 2'd1, 2'd1, 2'd3};
        do_reset();
        req_data = 32'h2300_2100;
        req_lock = 4'b0010;
        req = 4'b1010;
        for (int i = 0; i < 4; i++) begin
            serve(2, lk[i], d, g, a, e, w, ok);
            tests++; if (!ok || g !== exp_g[i]) begin fails++; $display("FAIL lock_grant%0d: got %0d want %0d (started %0b)", i, g, exp_g[i], ok); end
        end
        tests++; if (d !== 8'h23) begin fails++; $display("FAIL lock_last_data: got %h want 23", d); end
        req = 4'b0000;
        req_lock = 4'b0000;
        step();
    endtask

    task automatic test_lock_release();
        logic [7:0] d; logic [1:0] g; logic [3:0] a; logic e; int w; bit ok;
        do_reset();
        req_data = 32'h0042_0040;
        req = 4'b0001;
        serve(2, 4'b0001, d, g, a, e, w, ok);
        tests++; if (!ok || g !== 2'd0) begin fails++; $display("FAIL release_first: got %0d want 0", g); end
        req = 4'b0100;
        serve(2, 4'b0000, d, g, a, e, w, ok);
        tests++; if (!ok || g !== 2'd2) begin fails++; $display("FAIL release_grant: got %0d want 2", g); end
        tests++; if (d !== 8'h42) begin fails++; $display("FAIL release_data: got %h want 42", d); end
        tests++; if (w !== 2) begin fails++; $display("FAIL release_gap: got %0d want 2", w); end
        req = 4'b0000;
        step();
    endtask

    task automatic test_timeout();
        logic [7:0] d; logic [1:0] g; logic [3:0] a; logic e; int w; bit ok;
        int n;
        bit started;
        do_reset();
        req_data = 32'h0000_5150;
        req = 4'b0011;
        started = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (tx_start === 1'b1) begin started = 1'b1; break; end
            step();
        end
        tests++; if (!started) begin fails++; $display("FAIL timeout_start: no tx_start within bound"); end
        n = 0;
        while (n < 100 && req_ack === 4'b0000) begin
            step();
            n++;
        end
        tests++; if (n !== 50) begin fails++; $display("FAIL timeout_latency: got %0d want 50", n); end
        tests++; if (err !== 1'b1) begin fails++; $display("FAIL timeout_err: got %b want 1", err); end
        tests++; if (req_ack !== 4'b0001) begin fails++; $display("FAIL timeout_ack: got %b want 0001", req_ack); end
        req = 4'b0010;
        step();
        tests++; if (err !== 1'b0) begin fails++; $display("FAIL timeout_err_pulse: got %b want 0", err); end
        serve(2, 4'b0000, d, g, a, e, w, ok);
        tests++; if (!ok || g !== 2'd1 || d !== 8'h51) begin fails++; $display("FAIL timeout_next: got id %0d data %h want id 1 data 51", g, d); end
        tests++; if (e !== 1'b0 || a !== 4'b0010) begin fails++; $display("FAIL timeout_next_ack: got ack %b err %b want 0010 0", a, e); end
        req = 4'b0000;
        step();
    endtask

    task automatic test_reset_mid_wait();
        logic [7:0] d; logic [1:0] g; logic [3:0] a; logic e; int w; bit ok;
        do_reset();
        req_data = 32'h6300_0060;
        req = 4'b0010;
        serve(1, 4'b0000, d, g, a, e, w, ok);
        req = 4'b1000;
        step();
        step();
        tests++; if (tx_start !== 1'b1 || grant_id !== 2'd3) begin fails++; $display("FAIL midwait_setup: got start %b id %0d want 1 3", tx_start, grant_id); end
        repeat (5) step();
        rst = 1'b1;
        req = 4'b1001;
        #1;
        tests++; if ({tx_start, req_ack, busy, err} !== 7'b0) begin fails++; $display("FAIL midwait_outputs: got %b want 0000000", {tx_start, req_ack, busy, err}); end
        tests++; if (grant_id !== 2'd0 || tx_data !== 8'h00) begin fails++; $display("FAIL midwait_grant: got id %0d data %h want 0 00", grant_id, tx_data); end
        step();
        rst = 1'b0;
        serve(2, 4'b0000, d, g, a, e, w, ok);
        tests++; if (!ok || g !== 2'd0 || d !== 8'h60) begin fails++; $display("FAIL midwait_first: got id %0d data %h want 0 60", g, d); end
        tests++; if (e !== 1'b0 || a !== 4'b0001) begin fails++; $display("FAIL midwait_ack: got ack %b err %b want 0001 0", a, e); end
        req = 4'b0000;
        step();
    endtask

    initial begin
        rst      = 1'b1;
        req      = '0;
        req_lock = '0;
        req_data = '0;
        tx_done  = 1'b0;
        test_reset();
        test_single();
        test_first_cycle_done();
        test_contention();
        test_lock();
        test_lock_release();
        test_timeout();
        test_reset_mid_wait();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
